// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap sequencer: prioritises interrupts and sync events into registered csr trap commands
// Optional feature macro: TRAP_CTRL_VECTORED_EN (vectored interrupt targets when mtvec_i[1:0]==2'b01)
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext_i,
  input  logic        irq_soft_i,
  input  logic        irq_timer_i,
  input  logic        ecall_i,
  input  logic        illegal_i,
  input  logic        mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        stall_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] except_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        hold_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, SETTLE} state_t;
  state_t state;

  logic        ext_en, soft_en, tim_en, any_event;
  logic [31:0] cause, target, base;

  always_comb begin
    ext_en    = irq_ext_i   & mie_i[11] & mstatus_i[3];
    soft_en   = irq_soft_i  & mie_i[3]  & mstatus_i[3];
    tim_en    = irq_timer_i & mie_i[7]  & mstatus_i[3];
    base      = {mtvec_i[31:2], 2'b00};
    cause     = 32'h0000_0000;
    target    = base;
    any_event = 1'b1;
    if (illegal_i)    cause = 32'h0000_0002;
    else if (ecall_i) cause = 32'h0000_0008;
    else if (mret_i) begin
      cause  = 32'h0000_000A;
      target = mepc_i;
    end
    else if (ext_en)  cause = 32'h8000_000B;
    else if (soft_en) cause = 32'h8000_0000;
    else if (tim_en)  cause = 32'h8000_0007;
    else              any_event = 1'b0;
`ifdef TRAP_CTRL_VECTORED_EN
    // Only interrupts (cause[31]) use the vector table; sync events stay on the base.
    if (cause[31] && (mtvec_i[1:0] == 2'b01))
      target = base + {26'd0, cause[3:0], 2'b00};
`endif
  end

  logic unused_bits;
  assign unused_bits = ^{mstatus_i[31:4], mstatus_i[2:0], mie_i[31:12], mie_i[10:8],
                         mie_i[6:4], mie_i[2:0], mtvec_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      excepttype_o  <= 32'h0;
      except_addr_o <= 32'h0;
      new_pc_o      <= 32'h0;
      flush_o       <= 1'b0;
      hold_o        <= 1'b0;
    end else begin
      // Command outputs are a single-cycle pulse; zero them unless entering ISSUE.
      excepttype_o  <= 32'h0;
      except_addr_o <= 32'h0;
      new_pc_o      <= 32'h0;
      flush_o       <= 1'b0;
      case (state)
        IDLE, WAIT: begin
          if (any_event && !stall_i) begin
            state         <= ISSUE;
            excepttype_o  <= cause;
            except_addr_o <= inst_addr_i;
            new_pc_o      <= target;
            flush_o       <= 1'b1;
            hold_o        <= 1'b1;
          end else if (any_event) begin
            state  <= WAIT;
            hold_o <= 1'b1;
          end else begin
            state  <= IDLE;
            hold_o <= 1'b0;
          end
        end
        ISSUE: begin
          state  <= SETTLE;
          hold_o <= 1'b1;
        end
        SETTLE: begin
          state  <= IDLE;
          hold_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          hold_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_ext = 0, irq_soft = 0, irq_timer = 0;
  logic        ecall = 0, illegal = 0, mret = 0;
  logic [31:0] inst_addr = 0;
  logic        stall = 0;
  logic [31:0] mstatus = 0, mie = 0, mtvec = 0, mepc = 0;
  logic [31:0] excepttype, except_addr, new_pc;
  logic        flush, hold;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] vec_timer_pc;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .irq_ext_i(irq_ext), .irq_soft_i(irq_soft), .irq_timer_i(irq_timer),
    .ecall_i(ecall), .illegal_i(illegal), .mret_i(mret),
    .inst_addr_i(inst_addr), .stall_i(stall),
    .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .excepttype_o(excepttype), .except_addr_o(except_addr), .flush_o(flush),
    .new_pc_o(new_pc), .hold_o(hold)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_type"},  excepttype,  32'h0);
    check({tag, "_addr"},  except_addr, 32'h0);
    check({tag, "_pc"},    new_pc,      32'h0);
    check({tag, "_flush"}, {31'd0, flush}, 32'h0);
    check({tag, "_hold"},  {31'd0, hold},  32'h0);
  endtask

  initial begin
`ifdef TRAP_CTRL_VECTORED_EN
    vec_timer_pc = 32'h11C;
`else
    vec_timer_pc = 32'h100;
`endif
    tick(); tick();
    check_idle_outputs("reset");
    rst = 0;
    tick();
    check_idle_outputs("idle_after_reset");

    // external interrupt, no stall: one-cycle latency and one-cycle pulse
    mie = 32'h800; mstatus = 32'h8; mtvec = 32'h100; inst_addr = 32'h40; irq_ext = 1;
    tick();
    check("ext_type",  excepttype,  32'h8000_000B);
    check("ext_addr",  except_addr, 32'h40);
    check("ext_pc",    new_pc,      32'h100);
    check("ext_flush", {31'd0, flush}, 32'h1);
    irq_ext = 0; inst_addr = 32'h44;
    tick();
    check("ext_settle_flush", {31'd0, flush}, 32'h0);
    check("ext_settle_type",  excepttype, 32'h0);
    check("ext_settle_hold",  {31'd0, hold}, 32'h1);
    tick();
    check("ext_back_idle_hold", {31'd0, hold}, 32'h0);

    // timer interrupt held off by stall
    mie = 32'h80; irq_timer = 1; stall = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("wait_hold",  {31'd0, hold},  32'h1);
      check("wait_flush", {31'd0, flush}, 32'h0);
      tick();
    end
    stall = 0;
    tick();
    check("tim_type",  excepttype, 32'h8000_0007);
    check("tim_flush", {31'd0, flush}, 32'h1);
    check("tim_pc",    new_pc, 32'h100);
    irq_timer = 0;
    tick(); tick();

    // illegal beats external; csr then clears MIE so ext is never taken
    mie = 32'h800; mstatus = 32'h8; illegal = 1; irq_ext = 1; inst_addr = 32'h80;
    tick();
    check("ill_type", excepttype,  32'h2);
    check("ill_addr", except_addr, 32'h80);
    check("ill_pc",   new_pc,      32'h100);
    illegal = 0; mstatus = 32'h0;
    tick();
    check("ill_settle_flush", {31'd0, flush}, 32'h0);
    tick();
    check("ill_eval_flush", {31'd0, flush}, 32'h0);
    tick();
    check("ill_no_ext_flush", {31'd0, flush}, 32'h0);
    check("ill_no_ext_hold",  {31'd0, hold},  32'h0);
    irq_ext = 0;

    // mret first, pending ext follows exactly 3 cycles later after MIE restore
    mepc = 32'h244; mret = 1; irq_ext = 1; inst_addr = 32'h90;
    tick();
    check("mret_type", excepttype, 32'hA);
    check("mret_pc",   new_pc,     32'h244);
    mret = 0; mstatus = 32'h8;
    tick();
    check("mret_p1_flush", {31'd0, flush}, 32'h0);
    tick();
    check("mret_p2_flush", {31'd0, flush}, 32'h0);
    tick();
    check("mret_ext_type",  excepttype, 32'h8000_000B);
    check("mret_ext_flush", {31'd0, flush}, 32'h1);
    irq_ext = 0;
    tick(); tick();

    // ecall beats mret
    ecall = 1; mret = 1;
    tick();
    check("ecall_type", excepttype, 32'h8);
    check("ecall_pc",   new_pc,     32'h100);
    ecall = 0; mret = 0;
    tick(); tick();

    // soft beats timer
    mie = 32'h88; irq_soft = 1; irq_timer = 1;
    tick();
    check("soft_type", excepttype, 32'h8000_0000);
    irq_soft = 0; irq_timer = 0;
    tick(); tick();

    // masked interrupt (mie bit clear) is ignored
    mie = 32'h0; irq_ext = 1;
    tick();
    check("masked_flush", {31'd0, flush}, 32'h0);
    check("masked_hold",  {31'd0, hold},  32'h0);
    irq_ext = 0;

    // vectored target
    mie = 32'h80; mtvec = 32'h101; irq_timer = 1;
    tick();
    check("vec_type", excepttype, 32'h8000_0007);
    check("vec_pc",   new_pc,     vec_timer_pc);
    irq_timer = 0;
    tick(); tick();

    // reset during WAIT
    mtvec = 32'h100; irq_timer = 1; stall = 1;
    tick();
    check("rstw_hold_pre", {31'd0, hold}, 32'h1);
    rst = 1; stall = 0;
    tick();
    check_idle_outputs("rst_wait");
    irq_timer = 0; rst = 0;
    tick();
    check("rstw_after_flush", {31'd0, flush}, 32'h0);

    // reset during ISSUE
    irq_timer = 1;
    tick();
    check("rsti_flush_pre", {31'd0, flush}, 32'h1);
    rst = 1; irq_timer = 0;
    tick();
    check_idle_outputs("rst_issue");
    rst = 0;
    tick();
    check("rsti_after_flush", {31'd0, flush}, 32'h0);
    check("rsti_after_hold",  {31'd0, hold},  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
